// File: rtl/flag_branch_unit.sv
// flag_branch_unit: registers the ALU {z,n,v} status flags and resolves
// conditional branches against them. A taken branch is offered to the PC
// logic as a redirect. Branch-and-link forms then emit a single-cycle
// link-register write strobe.
module flag_branch_unit #(
   parameter int         W    = 32,
   parameter logic [2:0] SVEC = 3'b000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         alu_z,
   input  logic         alu_n,
   input  logic         alu_v,
   input  logic         flag_we,
   input  logic         clr_sv,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_cond,
   input  logic         req_link,
   input  logic [W-1:0] req_target,
   input  logic [W-1:0] req_pc4,
   output logic         br_valid,
   input  logic         br_ready,
   output logic [W-1:0] br_target,
   output logic         link_we,
   output logic [W-1:0] link_data,
   output logic [2:0]   flags,
   output logic         sticky_v
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_LINK = 2'd2
   } state_t;

   state_t         state_q;
   logic [2:0]     flags_q;
   logic           sticky_q;
   logic           br_valid_q;
   logic [W-1:0]   br_target_q;
   logic           link_q;
   logic [W-1:0]   pc4_q;
   logic           link_we_q;
   logic [W-1:0]   link_data_q;

   logic [2:0]     eff_flags_d;
   logic           taken_d;
   logic           accept_d;
   logic           sticky_d;

   // Flags seen by the condition check: forward the live ALU flags when they
   // are being written in the same cycle, so a compare-then-branch pair needs
   // no bubble.
   always_comb begin
      eff_flags_d = flags_q;
      if (flag_we) eff_flags_d = {alu_z, alu_n, alu_v};
   end

   // Condition decode over {z,n,v}.
   always_comb begin
      taken_d = 1'b0;
      case (req_cond)
         3'b000: taken_d = 1'b0;
         3'b001: taken_d = 1'b1;
         3'b010: taken_d = eff_flags_d[2];
         3'b011: taken_d = ~eff_flags_d[2];
         3'b100: taken_d = eff_flags_d[1];
         3'b101: taken_d = eff_flags_d[0];
         3'b110: taken_d = eff_flags_d[1] ^ eff_flags_d[0];
         3'b111: taken_d = eff_flags_d[2] | (eff_flags_d[1] ^ eff_flags_d[0]);
         default: taken_d = 1'b0;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign accept_d  = req_valid & req_ready;

   // The sticky bit is set whenever an overflow flag is written. A set in the
   // same cycle as a clear takes priority, so an overflow is never lost.
   always_comb begin
      sticky_d = sticky_q;
      if (clr_sv)            sticky_d = 1'b0;
      if (flag_we && alu_v)  sticky_d = 1'b1;
   end

   // Flag register, sticky overflow, and the branch/redirect/link FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         flags_q     <= SVEC;
         sticky_q    <= 1'b0;
         br_valid_q  <= 1'b0;
         br_target_q <= '0;
         link_q      <= 1'b0;
         pc4_q       <= '0;
         link_we_q   <= 1'b0;
         link_data_q <= '0;
      end else begin
         if (flag_we) flags_q <= {alu_z, alu_n, alu_v};
         sticky_q <= sticky_d;

         case (state_q)
            S_IDLE: begin
               link_we_q <= 1'b0;
               // A not-taken branch retires here with no state change.
               if (accept_d && taken_d) begin
                  br_target_q <= req_target;
                  pc4_q       <= req_pc4;
                  link_q      <= req_link;
                  br_valid_q  <= 1'b1;
                  state_q     <= S_HOLD;
               end
            end
            S_HOLD: begin
               // br_target_q stays frozen until the PC logic takes it.
               if (br_ready) begin
                  br_valid_q <= 1'b0;
                  if (link_q) begin
                     link_we_q   <= 1'b1;
                     link_data_q <= pc4_q;
                     state_q     <= S_LINK;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_LINK: begin
               link_we_q <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: begin
               br_valid_q <= 1'b0;
               link_we_q  <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign br_valid  = br_valid_q;
   assign br_target = br_target_q;
   assign link_we   = link_we_q;
   assign link_data = link_data_q;
   assign flags     = flags_q;
   assign sticky_v  = sticky_q;

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the ALU status interface: registers the zero/negative/overflow flags the ALU produces each cycle and resolves conditional branches against them.
- Sits between the ALU and PC-update logic.
- Accepts branch requests with a valid/ready handshake and issues a taken-branch redirect with its own handshake.
- Drives a register-file link write for branch-and-link forms (balrz family).

Parameters:
- W, 32, datapath/address width.
- SVEC, 0, reset value of the flag register {z,n,v}.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_z  in  1  ALU zero flag (zout).
- alu_n  in  1  ALU negative flag (n).
- alu_v  in  1  ALU overflow flag (v).
- flag_we  in  1  latch alu_z/n/v into flag register this cycle.
- clr_sv  in  1  clear sticky overflow.
- req_valid  in  1  branch request present.
- req_ready  out  1  unit can accept request.
- req_cond  in  3  condition select (see Behaviour).
- req_link  in  1  branch writes link register if taken.
- req_target  in  W  branch target.
- req_pc4  in  W  PC+4 of branch (link value).
- br_valid  out  1  taken redirect pending.
- br_ready  in  1  PC logic accepts redirect.
- br_target  out  W  redirect address.
- link_we  out  1  one-cycle link write strobe.
- link_data  out  W  link value.
- flags  out  3  registered {z,n,v}.
- sticky_v  out  1  overflow seen since last clear.

Behaviour:
- Reset: flags=SVEC, sticky_v=0, state IDLE, br_valid=0, link_we=0, br_target=0, link_data=0, req_ready=1. Reset mid-operation discards any pending branch or link write.
- Flag register: on flag_we, flags<={alu_z,alu_n,alu_v}; otherwise holds.
- sticky_v:
  - set when flag_we&alu_v;
  - clear when clr_sv;
  - set wins if both in the same cycle.
- Effective flags for evaluation:
  - if flag_we same cycle as request accept, use live alu_* (forwarding);
  - else use the registered flags.
- req_cond encoding:
  - 000 never; 001 always;
  - 010 Z; 011 !Z;
  - 100 N; 101 V;
  - 110 N^V (signed less);
  - 111 Z|(N^V) (signed less-or-equal).
- Accept occurs when req_valid&req_ready. req_ready=1 only in IDLE.
- FSM states and transitions:
  - IDLE, on accept:
    - not taken → stay IDLE, no outputs (zero latency, no bubble);
    - taken → capture target/pc4/link, go HOLD.
  - HOLD: br_valid=1 with br_target stable.
    - br_valid stays high until br_ready; br_target must not change while waiting.
    - on br_ready: go LINK if the captured link=1, else go IDLE.
  - LINK:
    - link_we=1, link_data=captured pc4 for exactly one cycle;
    - then IDLE.
- Latency:
  - taken branch: br_valid asserted cycle after accept;
  - link write: cycle after the br handshake;
  - next request accepted the cycle after returning to IDLE.
- br_ready while br_valid=0 is ignored.
- flag_we during HOLD/LINK updates flags normally; a captured decision is not re-evaluated.
- Width: targets and pc4 are passed unmodified (no arithmetic).

Test Plan:
1. Reset, then req cond=010 with flags z=0 → no br_valid ever, req_ready stays 1, flags=000.
2. flag_we with alu_z=1 same cycle as req cond=010, target=0x00400020 → forwarded, br_valid=1 next cycle, br_target=0x00400020.
3. flags {z,n,v}=011, cond=110 → not taken (N^V=0); flags=010, cond=110 → taken; flags=100, cond=111 → taken.
4. Taken branch with link=1, pc4=0x00400008, br_ready held 0 for 3 cycles then 1 → br_valid stable for 4 cycles; link_we=1 with link_data=0x00400008 for exactly one cycle after the handshake; req_ready=0 throughout.
5. flag_we with alu_v=1 → sticky_v=1; then flag_we with alu_v=0 → sticky_v stays 1; clr_sv and alu_v=1 same cycle → sticky_v=1; clr_sv alone → 0.
6. reset asserted in HOLD → next cycle br_valid=0, link_we=0, req_ready=1, flags=SVEC, and no link write occurs.
